// File: rtl/axi4_wr_burst_ctrl.sv
// AXI4 write-burst master sequencer: one INCR burst per accepted command,
// payload streamed from a valid/ready source, B response reported on done.
module axi4_wr_burst_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [DATA_WIDTH-1:0]   src_data,
    output logic                    done,
    output logic [1:0]              done_resp,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG2 = $clog2(BYTES);
    localparam int unsigned PAGE      = 4096;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_awlen;
    logic [7:0]            r_cnt;
    logic                  r_done;
    logic [1:0]            r_done_resp;

    logic                  w_cmd_hs;
    logic                  w_w_hs;
    logic                  w_last_beat;
    logic                  w_misaligned;
    logic                  w_cross_page;
    logic                  w_reject;
    logic [31:0]           w_burst_end;

    // Legality of the offered command: beat-aligned and inside one 4KB page
    assign w_burst_end  = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * BYTES;
    assign w_misaligned = (32'(cmd_addr) % BYTES) != 32'd0;
    assign w_cross_page = w_burst_end > PAGE;
    assign w_reject     = w_misaligned | w_cross_page;

    assign w_cmd_hs    = cmd_valid & cmd_ready;
    assign w_w_hs      = wvalid & wready;
    assign w_last_beat = (r_cnt == r_awlen);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd_hs && !w_reject) w_state_nxt = ST_ADDR;
            ST_ADDR: if (awready)               w_state_nxt = ST_DATA;
            ST_DATA: if (w_w_hs && w_last_beat) w_state_nxt = ST_RESP;
            ST_RESP: if (bvalid)                w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, beat counter and completion reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awaddr    <= '0;
            r_awlen     <= 8'd0;
            r_cnt       <= 8'd0;
            r_done      <= 1'b0;
            r_done_resp <= 2'b00;
        end else begin
            r_done <= 1'b0;
            if (w_cmd_hs) begin
                r_awaddr <= cmd_addr;
                r_awlen  <= cmd_len;
                if (w_reject) begin
                    r_done      <= 1'b1;
                    r_done_resp <= 2'b10;
                end
            end
            if (r_state == ST_ADDR && awready) begin
                r_cnt <= 8'd0;
            end else if (r_state == ST_DATA && w_w_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == ST_RESP && bvalid) begin
                r_done      <= 1'b1;
                r_done_resp <= bresp;
            end
        end
    end

    // Idle is masked while done is pulsing so a new command never overlaps it
    assign cmd_ready = (r_state == ST_IDLE) & ~r_done & ~rst;

    assign awaddr    = r_awaddr;
    assign awlen     = r_awlen;
    assign awsize    = 3'(SIZE_LOG2);
    assign awburst   = 2'b01;
    assign awvalid   = (r_state == ST_ADDR);

    assign wdata     = src_data;
    assign wstrb     = '1;
    assign wvalid    = (r_state == ST_DATA) & src_valid;
    assign wlast     = (r_state == ST_DATA) & w_last_beat;
    assign src_ready = (r_state == ST_DATA) & wready;

    assign bready    = (r_state == ST_RESP);
    assign done      = r_done;
    assign done_resp = r_done_resp;

endmodule
